// File: rtl/uart_mem_bridge_if.sv
// rtl/uart_mem_bridge_if.sv - UART byte stream and memory debug port bundle for uart_mem_bridge
interface uart_mem_bridge_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        enable;
  logic        write_mem_req;
  logic        target_mem_type;
  logic [8:0]  target_addr;
  logic [31:0] uart_rx_data_in;
  logic        rw_flag;
  logic [41:0] mem_tx_data;
  logic        mem_tx_ready;
  logic        busy;
  logic        rx_overrun;

  // Bridge side
  modport slave (
    input  rx_byte, rx_valid, tx_ready, enable, mem_tx_data, mem_tx_ready,
    output tx_byte, tx_valid, write_mem_req, target_mem_type, target_addr,
           uart_rx_data_in, rw_flag, busy, rx_overrun
  );

  // UART / memory / CPU side
  modport master (
    output rx_byte, rx_valid, tx_ready, enable, mem_tx_data, mem_tx_ready,
    input  tx_byte, tx_valid, write_mem_req, target_mem_type, target_addr,
           uart_rx_data_in, rw_flag, busy, rx_overrun
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// rtl/uart_mem_bridge.sv - UART debug frame parser issuing memory requests; WRITE_ACK_EN adds a 0xA5 write ack
module uart_mem_bridge #(
  parameter int RESP_TIMEOUT = 255,
  parameter int HALT_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_mem_bridge_if.slave bus
);
  localparam logic [15:0] RESP_LIM = 16'(RESP_TIMEOUT);
  localparam logic [15:0] HALT_LIM = 16'(HALT_TIMEOUT);
  localparam logic [7:0]  ERR_BYTE = 8'hEE;
  localparam logic [7:0]  ACK_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    S_HDR, S_ADDR, S_DATA, S_HALT, S_REQ, S_WAIT, S_TX, S_ACK, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        pend_rw_q, pend_rw_d;
  logic        pend_type_q, pend_type_d;
  logic [8:0]  pend_addr_q, pend_addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [41:0] resp_q, resp_d;
  logic        rw_q, rw_d;
  logic        type_q, type_d;
  logic [8:0]  taddr_q, taddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        overrun_q, overrun_d;
  logic        req_c;
  logic        tx_valid_c;
  logic [7:0]  tx_byte_c;
  logic        accepting;

  // Header bits 5:1 carry no meaning in the frame format
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^bus.rx_byte[5:1];

  // State and datapath registers; reset discards any frame or reply in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_HDR;
      pend_rw_q   <= 1'b0;
      pend_type_q <= 1'b0;
      pend_addr_q <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      resp_q      <= '0;
      rw_q        <= 1'b0;
      type_q      <= 1'b0;
      taddr_q     <= '0;
      wdata_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_rw_q   <= pend_rw_d;
      pend_type_q <= pend_type_d;
      pend_addr_q <= pend_addr_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      rw_q        <= rw_d;
      type_q      <= type_d;
      taddr_q     <= taddr_d;
      wdata_q     <= wdata_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, frame parsing, timeouts and tx byte selection
  always_comb begin
    state_d     = state_q;
    pend_rw_d   = pend_rw_q;
    pend_type_d = pend_type_q;
    pend_addr_d = pend_addr_q;
    data_d      = data_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    rw_d        = rw_q;
    type_d      = type_q;
    taddr_d     = taddr_q;
    wdata_d     = wdata_q;
    req_c       = 1'b0;
    tx_valid_c  = 1'b0;
    tx_byte_c   = 8'h00;
    accepting   = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_DATA);
    overrun_d   = overrun_q | (bus.rx_valid & ~accepting);

    case (state_q)
      S_HDR: begin
        if (bus.rx_valid) begin
          pend_rw_d   = bus.rx_byte[7];
          pend_type_d = bus.rx_byte[6];
          pend_addr_d = {bus.rx_byte[0], pend_addr_q[7:0]};
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.rx_valid) begin
          pend_addr_d = {pend_addr_q[8], bus.rx_byte};
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = pend_rw_q ? S_DATA : S_HALT;
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          data_d = {data_q[23:0], bus.rx_byte};
          if (idx_q == 3'd3) begin
            cnt_d   = '0;
            state_d = S_HALT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_HALT: begin
        if (!bus.enable) begin
          rw_d    = pend_rw_q;
          type_d  = pend_type_q;
          taddr_d = pend_addr_q;
          wdata_d = data_q;
          state_d = S_REQ;
        end else if (cnt_q >= HALT_LIM) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_REQ: begin
        req_c = 1'b1;
        cnt_d = '0;
        if (rw_q) begin
`ifdef WRITE_ACK_EN
          state_d = S_ACK;
`else
          state_d = S_HDR;
`endif
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_tx_ready) begin
          resp_d  = bus.mem_tx_data;
          idx_d   = '0;
          state_d = S_TX;
        end else if (cnt_q >= RESP_LIM) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_TX: begin
        tx_valid_c = 1'b1;
        case (idx_q)
          3'd0:    tx_byte_c = {6'b0, resp_q[41:40]};
          3'd1:    tx_byte_c = resp_q[39:32];
          3'd2:    tx_byte_c = resp_q[31:24];
          3'd3:    tx_byte_c = resp_q[23:16];
          3'd4:    tx_byte_c = resp_q[15:8];
          default: tx_byte_c = resp_q[7:0];
        endcase
        if (bus.tx_ready) begin
          if (idx_q == 3'd5) state_d = S_HDR;
          else               idx_d   = idx_q + 3'd1;
        end
      end
`ifdef WRITE_ACK_EN
      S_ACK: begin
        tx_valid_c = 1'b1;
        tx_byte_c  = ACK_BYTE;
        if (bus.tx_ready) state_d = S_HDR;
      end
`endif
      S_ERR: begin
        tx_valid_c = 1'b1;
        tx_byte_c  = ERR_BYTE;
        if (bus.tx_ready) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  assign bus.tx_valid        = tx_valid_c;
  assign bus.tx_byte         = tx_byte_c;
  assign bus.write_mem_req   = req_c;
  assign bus.rw_flag         = rw_q;
  assign bus.target_mem_type = type_q;
  assign bus.target_addr     = taddr_q;
  assign bus.uart_rx_data_in = wdata_q;
  assign bus.busy            = (state_q != S_HDR);
  assign bus.rx_overrun      = overrun_q;
endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb/tb_uart_mem_bridge.sv - directed self-checking bench for uart_mem_bridge
module tb_uart_mem_bridge;
  localparam int RESP_TO = 255;
  localparam int HALT_TO = 400;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_mem_bridge_if bus();

  uart_mem_bridge #(.RESP_TIMEOUT(RESP_TO), .HALT_TIMEOUT(HALT_TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic        rw;
    logic        mt;
    logic [8:0]  addr;
    logic [31:0] data;
  } req_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int n_req = 0;
  int last_acc_cyc = 0;
  int last_req_cyc = 0;
  bit exp_overrun = 0;
  bit mem_mute = 0;
  bit bp_mode = 0;

  req_t        exp_req_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [31:0] model_mem [0:1023];
  logic [31:0] phys [0:1023];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle count and transmitter ready pattern (1 of 3 cycles under backpressure)
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.tx_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  // Registered memory: read data returned the cycle after the request
  initial begin
    logic [41:0] r;
    bus.mem_tx_ready = 1'b0;
    bus.mem_tx_data  = '0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.write_mem_req) begin
        if (bus.rw_flag) begin
          phys[{bus.target_mem_type, bus.target_addr}] = bus.uart_rx_data_in;
        end else if (!mem_mute) begin
          r = {1'b0, bus.target_addr, phys[{bus.target_mem_type, bus.target_addr}]};
          @(posedge clk); #1;
          bus.mem_tx_data  = r;
          bus.mem_tx_ready = 1'b1;
          @(posedge clk); #1;
          bus.mem_tx_ready = 1'b0;
          bus.mem_tx_data  = '0;
        end
      end
    end
  end

  // Compare process: requests, accepted tx bytes, stall stability, overrun flag
  initial begin
    bit         prev_stall;
    bit         prev_req;
    logic [7:0] prev_byte;
    req_t       r;
    prev_stall = 0;
    prev_req   = 0;
    prev_byte  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 0;
        prev_req   = 0;
      end else begin
        chk("rx_overrun", bus.rx_overrun, exp_overrun);
        if (prev_stall) begin
          chk("stall_valid", bus.tx_valid, 1);
          chk("stall_byte", bus.tx_byte, prev_byte);
        end
        if (prev_req) chk("req_one_cycle", bus.write_mem_req, 0);
        if (bus.write_mem_req) begin
          n_req++;
          last_req_cyc = cyc;
          if (exp_req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req actual addr=%0h required none", bus.target_addr);
          end else begin
            r = exp_req_q.pop_front();
            chk("req_rw", bus.rw_flag, r.rw);
            chk("req_type", bus.target_mem_type, r.mt);
            chk("req_addr", bus.target_addr, r.addr);
            if (r.rw) chk("req_data", bus.uart_rx_data_in, r.data);
          end
        end
        if (bus.tx_valid && bus.tx_ready) begin
          acc_cnt++;
          last_acc_cyc = cyc;
          if (exp_tx_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_tx actual=%0h required none", bus.tx_byte);
          end else begin
            chk("tx_byte", bus.tx_byte, exp_tx_q.pop_front());
          end
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_byte  = bus.tx_byte;
        prev_req   = bus.write_mem_req;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic rw, input logic mt, input logic [8:0] addr, input logic [31:0] data);
    logic [7:0] h;
    h = {rw, mt, 5'b0, addr[8]};
    send(h);
    send(addr[7:0]);
    if (rw) begin
      send(data[31:24]);
      send(data[23:16]);
      send(data[15:8]);
      send(data[7:0]);
    end
  endtask

  task automatic expect_write(input logic mt, input logic [8:0] addr, input logic [31:0] data);
    req_t r;
    r.rw = 1'b1; r.mt = mt; r.addr = addr; r.data = data;
    exp_req_q.push_back(r);
    model_mem[{mt, addr}] = data;
`ifdef WRITE_ACK_EN
    exp_tx_q.push_back(8'hA5);
`endif
  endtask

  // Reply = 42-bit word {0, addr, data} cut into 6 bytes, top 2 bits first
  task automatic expect_read(input logic mt, input logic [8:0] addr);
    req_t r;
    logic [41:0] w;
    r.rw = 1'b0; r.mt = mt; r.addr = addr; r.data = '0;
    exp_req_q.push_back(r);
    w = {1'b0, addr, model_mem[{mt, addr}]};
    for (int i = 0; i < 6; i++) exp_tx_q.push_back(8'((w >> (8 * (5 - i))) & 42'hFF));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_tx_q.size() != 0 || exp_req_q.size() != 0 || bus.busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=pending(%0d tx,%0d req) required=drained", name, exp_tx_q.size(), exp_req_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, base, n;
    for (int i = 0; i < 1024; i++) begin
      phys[i] = '0;
      model_mem[i] = '0;
    end
    bus.rx_byte  = '0;
    bus.rx_valid = 1'b0;
    bus.enable   = 1'b0;
    reset_n      = 1'b0;
    step(); step(); step();
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req", bus.write_mem_req, 0);
    chk("rst_addr", bus.target_addr, 0);
    chk("rst_wdata", bus.uart_rx_data_in, 0);
    chk("rst_rw", bus.rw_flag, 0);
    chk("rst_overrun", bus.rx_overrun, 0);
    reset_n = 1'b1;
    step();

    // Write 0xDEADBEEF to data memory word 0x005
    expect_write(1'b0, 9'h005, 32'hDEADBEEF);
    send_frame(1'b1, 1'b0, 9'h005, 32'hDEADBEEF);
    wait_drain("write", 100);
    chk("write_hold_addr", bus.target_addr, 9'h005);
    chk("write_hold_data", bus.uart_rx_data_in, 32'hDEADBEEF);
    chk("write_hold_rw", bus.rw_flag, 1);

    // Read instruction memory 0x123, hand-computed reply bytes
    phys[{1'b1, 9'h123}]      = 32'h12345678;
    model_mem[{1'b1, 9'h123}] = 32'h12345678;
    begin
      req_t r;
      r.rw = 1'b0; r.mt = 1'b1; r.addr = 9'h123; r.data = '0;
      exp_req_q.push_back(r);
    end
    exp_tx_q.push_back(8'h01); exp_tx_q.push_back(8'h23); exp_tx_q.push_back(8'h12);
    exp_tx_q.push_back(8'h34); exp_tx_q.push_back(8'h56); exp_tx_q.push_back(8'h78);
    base = acc_cnt;
    send_frame(1'b0, 1'b1, 9'h123, 32'h0);
    wait_drain("read", 100);
    chk("read_byte_count", acc_cnt - base, 6);
    chk("read_hold_type", bus.target_mem_type, 1);
    chk("read_hold_rw", bus.rw_flag, 0);

    // Read back the written word under 1-of-3 backpressure
    bp_mode = 1;
    base = acc_cnt;
    expect_read(1'b0, 9'h005);
    send_frame(1'b0, 1'b0, 9'h005, 32'h0);
    wait_drain("backpressure", 200);
    chk("bp_byte_count", acc_cnt - base, 6);
    bp_mode = 0;

    // Halt gating: frame completes with CPU running, released after 50 cycles
    bus.enable = 1'b1;
    base = n_req;
    send_frame(1'b1, 1'b0, 9'h110, 32'hCAFEF00D);
    repeat (50) step();
    chk("halt_no_req", n_req - base, 0);
    expect_write(1'b0, 9'h110, 32'hCAFEF00D);
    t0 = cyc;
    bus.enable = 1'b0;
    wait_drain("halt_release", 100);
    chk("halt_release_latency_ok", ((last_req_cyc - t0) >= 1) && ((last_req_cyc - t0) <= 2), 1);

    // Halt timeout: CPU never halts, error byte and no request
    bus.enable = 1'b1;
    base = n_req;
    exp_tx_q.push_back(8'hEE);
    send_frame(1'b0, 1'b0, 9'h007, 32'h0);
    t0 = cyc;
    wait_drain("halt_timeout", HALT_TO + 60);
    chk("halt_to_latency_ok", ((last_acc_cyc - t0) >= HALT_TO) && ((last_acc_cyc - t0) <= HALT_TO + 6), 1);
    chk("halt_to_no_req", n_req - base, 0);
    bus.enable = 1'b0;

    // Response timeout with a byte injected while waiting
    mem_mute = 1;
    begin
      req_t r;
      r.rw = 1'b0; r.mt = 1'b0; r.addr = 9'h005; r.data = '0;
      exp_req_q.push_back(r);
    end
    exp_tx_q.push_back(8'hEE);
    base = n_req;
    send_frame(1'b0, 1'b0, 9'h005, 32'h0);
    n = 0;
    while (n_req == base && n < 20) begin
      step();
      n++;
    end
    chk("resp_to_req_seen", n_req - base, 1);
    t0 = last_req_cyc;
    repeat (5) step();
    send(8'h55);
    exp_overrun = 1;
    wait_drain("resp_timeout", RESP_TO + 60);
    chk("resp_to_latency_ok", ((last_acc_cyc - t0) >= RESP_TO) && ((last_acc_cyc - t0) <= RESP_TO + 6), 1);
    mem_mute = 0;
    expect_read(1'b1, 9'h123);
    send_frame(1'b0, 1'b1, 9'h123, 32'h0);
    wait_drain("after_overrun", 100);

    // Reset after the third reply byte is accepted
    expect_read(1'b1, 9'h123);
    base = acc_cnt;
    send_frame(1'b0, 1'b1, 9'h123, 32'h0);
    n = 0;
    while (acc_cnt < base + 3 && n < 50) begin
      step();
      n++;
    end
    chk("midtx_reached_3", acc_cnt - base, 3);
    reset_n = 1'b0;
    exp_tx_q.delete();
    exp_req_q.delete();
    exp_overrun = 0;
    #1;
    chk("midtx_tx_valid", bus.tx_valid, 0);
    chk("midtx_busy", bus.busy, 0);
    chk("midtx_overrun", bus.rx_overrun, 0);
    step(); step();
    reset_n = 1'b1;
    repeat (10) step();
    chk("post_reset_no_tx", acc_cnt - base, 3);

    // Parser works after reset
    expect_read(1'b0, 9'h110);
    send_frame(1'b0, 1'b0, 9'h110, 32'h0);
    wait_drain("post_reset_read", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
